// File: rtl/tpseqsys_sw_pkg.sv
// Purpose: shared types and constants for the slide-switch debouncer.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control on a level-conditioning path).
package tpseqsys_sw_pkg;

    localparam int SW_WIDTH                 = 10;
    localparam int SW_STABLE_CYCLES_DEFAULT = 1_000_000;

    typedef logic [SW_WIDTH-1:0] sw_bus_t;

    // MATCH: synchronized input equals the debounced level.
    // PENDING: they differ and the persistence counter is running.
    typedef enum logic {
        DB_MATCH   = 1'b0,
        DB_PENDING = 1'b1
    } db_state_t;

endpackage

// File: rtl/tpseqsys_debounce_bit.sv
// Purpose: synchronize and debounce one switch bit.
// Latency: SYNC_STAGES + STABLE_CYCLES clocks from a clean raw edge to sw_stable_o.
// Backpressure: none; the output is a level and the change flag is a single-cycle pulse.
// Ports: clk_i, reset_n_i (sync, active-low), sw_raw_i (async pin),
//        sw_stable_o (debounced level), sw_changed_o (1-cycle toggle pulse).
module tpseqsys_debounce_bit
    import tpseqsys_sw_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = SW_STABLE_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic sw_raw_i,
    output logic sw_stable_o,
    output logic sw_changed_o
);

    localparam int            CW       = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    db_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   changed_q, changed_d;
    logic                   s;

    // Oldest stage is the synchronized sample the FSM acts on.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], sw_raw_i};
    assign s      = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            sync_q    <= '0;
            state_q   <= DB_MATCH;
            cnt_q     <= '0;
            stable_q  <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            changed_q <= changed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stable_d  = stable_q;
        changed_d = 1'b0;
        case (state_q)
            DB_MATCH: begin
                if (s != stable_q) begin
                    state_d = DB_PENDING;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            DB_PENDING: begin
                if (s == stable_q) begin
                    // Glitch: level fell back before persisting long enough.
                    state_d = DB_MATCH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Terminal count: accept the new level; counter never wraps.
                    state_d   = DB_MATCH;
                    cnt_d     = '0;
                    stable_d  = s;
                    changed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    assign sw_stable_o  = stable_q;
    assign sw_changed_o = changed_q;

endmodule

// File: rtl/tpseqsys_switch_debouncer.sv
// Purpose: condition WIDTH raw slide-switch pins into a glitch-free bus for the PIO in_port.
// Latency: SYNC_STAGES + STABLE_CYCLES clocks from a clean raw edge to sw_stable.
// Backpressure: none; outputs are levels/pulses, capture flags are sticky until cleared.
// Ports: clk, reset_n (sync, active-low), sw_raw (async pins), sw_stable (debounced bus),
//        sw_changed (per-bit toggle pulse); with SW_DEBOUNCE_IRQ_EN defined also
//        edge_clear (write-1-to-clear), edge_capture (sticky toggle flags), irq (OR of flags).
module tpseqsys_switch_debouncer
    import tpseqsys_sw_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = SW_STABLE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_changed
`ifdef SW_DEBOUNCE_IRQ_EN
    ,
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] edge_capture,
    output logic             irq
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tpseqsys_debounce_bit #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_bit (
            .clk_i        (clk),
            .reset_n_i    (reset_n),
            .sw_raw_i     (sw_raw[i]),
            .sw_stable_o  (sw_stable[i]),
            .sw_changed_o (sw_changed[i])
        );
    end

`ifdef SW_DEBOUNCE_IRQ_EN
    logic [WIDTH-1:0] capture_q, capture_d;
    logic             irq_q, irq_d;

    // Set has priority over a simultaneous clear so no toggle is lost.
    assign capture_d = (capture_q & ~edge_clear) | sw_changed;
    // Registered from the flags, so irq trails edge_capture by one cycle.
    assign irq_d     = |capture_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            capture_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            capture_q <= capture_d;
            irq_q     <= irq_d;
        end
    end

    assign edge_capture = capture_q;
    assign irq          = irq_q;
`endif

endmodule

// File: tb/tb_tpseqsys_switch_debouncer.sv
module tb_tpseqsys_switch_debouncer;
    import tpseqsys_sw_pkg::*;

    localparam int NV = 14;

    typedef struct {
        sw_bus_t raw;
        int      ticks;
        sw_bus_t exp_stable;
        sw_bus_t exp_changed;
    } vec_t;

    logic    clk = 1'b0;
    logic    reset_n;
    sw_bus_t sw_raw;
    sw_bus_t sw_stable;
    sw_bus_t sw_changed;
`ifdef SW_DEBOUNCE_IRQ_EN
    sw_bus_t edge_clear;
    sw_bus_t edge_capture;
    logic    irq;
`endif

    int total = 0;
    int bad   = 0;

    tpseqsys_switch_debouncer #(
        .WIDTH         (SW_WIDTH),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sw_raw       (sw_raw),
        .sw_stable    (sw_stable),
        .sw_changed   (sw_changed)
`ifdef SW_DEBOUNCE_IRQ_EN
        ,
        .edge_clear   (edge_clear),
        .edge_capture (edge_capture),
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    vec_t vecs[NV];

    initial begin
        int pulses;
        int rise;

        // Expectations with SYNC_STAGES=2, STABLE_CYCLES=8: a new level
        // shows on sw_stable 10 clocks after it is applied.
        vecs[0]  = '{raw: 10'h001, ticks: 2,  exp_stable: 10'h001, exp_changed: 10'h000};
        vecs[1]  = '{raw: 10'h009, ticks: 5,  exp_stable: 10'h001, exp_changed: 10'h000};
        vecs[2]  = '{raw: 10'h001, ticks: 12, exp_stable: 10'h001, exp_changed: 10'h000};
        vecs[3]  = '{raw: 10'h000, ticks: 9,  exp_stable: 10'h001, exp_changed: 10'h000};
        vecs[4]  = '{raw: 10'h000, ticks: 1,  exp_stable: 10'h000, exp_changed: 10'h001};
        vecs[5]  = '{raw: 10'h000, ticks: 1,  exp_stable: 10'h000, exp_changed: 10'h000};
        vecs[6]  = '{raw: 10'h3FF, ticks: 9,  exp_stable: 10'h000, exp_changed: 10'h000};
        vecs[7]  = '{raw: 10'h3FF, ticks: 1,  exp_stable: 10'h3FF, exp_changed: 10'h3FF};
        vecs[8]  = '{raw: 10'h3FF, ticks: 1,  exp_stable: 10'h3FF, exp_changed: 10'h000};
        vecs[9]  = '{raw: 10'h2AA, ticks: 9,  exp_stable: 10'h3FF, exp_changed: 10'h000};
        vecs[10] = '{raw: 10'h2AA, ticks: 1,  exp_stable: 10'h2AA, exp_changed: 10'h155};
        vecs[11] = '{raw: 10'h155, ticks: 10, exp_stable: 10'h155, exp_changed: 10'h3FF};
        vecs[12] = '{raw: 10'h155, ticks: 1,  exp_stable: 10'h155, exp_changed: 10'h000};
        vecs[13] = '{raw: 10'h000, ticks: 11, exp_stable: 10'h000, exp_changed: 10'h000};

        // Reset with inputs low.
        reset_n = 1'b0;
        sw_raw  = '0;
`ifdef SW_DEBOUNCE_IRQ_EN
        edge_clear = '0;
`endif
        repeat (3) tick();
        check("reset_stable", 32'(sw_stable), 32'h0);
        check("reset_changed", 32'(sw_changed), 32'h0);
`ifdef SW_DEBOUNCE_IRQ_EN
        check("reset_capture", 32'(edge_capture), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
`endif
        reset_n = 1'b1;

        // Bit 0 rises: exactly 10 cycles later, one-cycle change pulse.
        sw_raw = 10'h001;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("rise0_stable_t%0d", i), 32'(sw_stable), (i == 10) ? 32'h001 : 32'h0);
            check($sformatf("rise0_changed_t%0d", i), 32'(sw_changed), (i == 10) ? 32'h001 : 32'h0);
        end
        tick();
        check("rise0_changed_after", 32'(sw_changed), 32'h0);
        check("rise0_stable_after", 32'(sw_stable), 32'h001);

        // Table: short pulse rejection, all-bit changes, mixed patterns.
        for (int v = 0; v < NV; v++) begin
            sw_raw = vecs[v].raw;
            repeat (vecs[v].ticks) tick();
            check($sformatf("vec%0d_stable", v), 32'(sw_stable), 32'(vecs[v].exp_stable));
            check($sformatf("vec%0d_changed", v), 32'(sw_changed), 32'(vecs[v].exp_changed));
        end

        // Bounce bit 5 every 3 cycles for 40 cycles, then hold high.
        pulses = 0;
        rise   = -1;
        for (int k = 0; k < 60; k++) begin
            sw_raw = (k >= 40 || ((k / 3) % 2) == 0) ? 10'h020 : 10'h000;
            tick();
            if (sw_changed[5]) pulses++;
            if (sw_stable[5] && rise < 0) rise = k + 1 - 40;
        end
        check("bounce_pulses", 32'(pulses), 32'd1);
        check("bounce_rise_delay", 32'(rise), 32'd10);
        check("bounce_stable", 32'(sw_stable), 32'h020);

        // Reset in the middle of a pending rise on bit 0 (count 4).
        sw_raw = 10'h021;
        repeat (6) tick();
        check("pend_before_reset", 32'(sw_stable), 32'h020);
        reset_n = 1'b0;
        tick();
        check("midreset_stable", 32'(sw_stable), 32'h0);
        check("midreset_changed", 32'(sw_changed), 32'h0);
`ifdef SW_DEBOUNCE_IRQ_EN
        check("midreset_capture", 32'(edge_capture), 32'h0);
        check("midreset_irq", 32'(irq), 32'h0);
`endif
        reset_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("postrst_stable_t%0d", i), 32'(sw_stable), (i == 10) ? 32'h021 : 32'h0);
            check($sformatf("postrst_changed_t%0d", i), 32'(sw_changed), (i == 10) ? 32'h021 : 32'h0);
        end
        tick();
        check("postrst_changed_after", 32'(sw_changed), 32'h0);

`ifdef SW_DEBOUNCE_IRQ_EN
        // Flags from the post-reset rise are set; clear them all.
        check("cap_after_postrst", 32'(edge_capture), 32'h021);
        edge_clear = 10'h3FF;
        tick();
        check("cap_clear_all", 32'(edge_capture), 32'h0);
        edge_clear = '0;
        tick();
        check("irq_clear_all", 32'(irq), 32'h0);

        // Toggle bit 2: capture one cycle after the pulse, irq one after that.
        sw_raw = 10'h025;
        repeat (10) tick();
        check("b2_changed", 32'(sw_changed), 32'h004);
        tick();
        check("b2_capture", 32'(edge_capture), 32'h004);
        check("b2_irq_lag", 32'(irq), 32'h0);
        tick();
        check("b2_irq", 32'(irq), 32'h1);

        // Clear coincident with a new bit-2 change: set wins.
        sw_raw = 10'h021;
        repeat (10) tick();
        check("b2_fall_changed", 32'(sw_changed), 32'h004);
        edge_clear = 10'h004;
        tick();
        check("b2_set_wins", 32'(edge_capture), 32'h004);
        edge_clear = '0;
        tick();
        check("b2_set_wins_hold", 32'(edge_capture), 32'h004);
        check("b2_irq_hold", 32'(irq), 32'h1);
        edge_clear = 10'h004;
        tick();
        check("b2_clear_alone", 32'(edge_capture), 32'h0);
        edge_clear = '0;
        tick();
        check("b2_irq_drop", 32'(irq), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
